// File: rtl/dac_wavegen_pkg.sv
// dac_wavegen_pkg: mode, cfg address and controller state encodings shared by the waveform generator.
package dac_wavegen_pkg;
    typedef enum logic [1:0] {
        MODE_RAMP     = 2'd0,
        MODE_TRIANGLE = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_CONST    = 2'd3
    } mode_t;
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
    localparam logic [1:0] CFG_MODE  = 2'd0;
    localparam logic [1:0] CFG_INC   = 2'd1;
    localparam logic [1:0] CFG_LEVEL = 2'd2;
    localparam logic [1:0] CFG_RSVD  = 2'd3;
endpackage

// File: rtl/dac_wavegen_ch.sv
// dac_wavegen_ch: one DAC channel - shadow/active config, phase accumulator, waveform mux, output register.
// Build option DAC_WAVEGEN_INVERT_EN inverts every output bit, midscale included.
module dac_wavegen_ch
    import dac_wavegen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [ACC_W-1:0]  data,
    input  logic              clear,
    input  logic              advance,
    input  logic              commit,
    input  logic              stop,
    output logic [DATA_W-1:0] dout
);
    localparam logic [DATA_W-1:0] MID     = DATA_W'(1) << (DATA_W - 1);
    localparam logic [ACC_W-1:0]  INC_RST = ACC_W'(1) << (ACC_W - DATA_W);
`ifdef DAC_WAVEGEN_INVERT_EN
    localparam logic [DATA_W-1:0] OUT_XOR = '1;
`else
    localparam logic [DATA_W-1:0] OUT_XOR = '0;
`endif

    mode_t             mode_s, mode_a;
    logic [ACC_W-1:0]  inc_s, inc_a, acc;
    logic [DATA_W-1:0] level_s, level_a, p, wave;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mode_s  <= MODE_RAMP;
            inc_s   <= INC_RST;
            level_s <= MID;
        end else if (we) begin
            if (addr == CFG_MODE)  mode_s  <= mode_t'(data[1:0]);
            if (addr == CFG_INC)   inc_s   <= data;
            if (addr == CFG_LEVEL) level_s <= data[DATA_W-1:0];
        end
    end

    // Commit samples the shadow before any same-cycle write lands, so that write stays pending.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mode_a  <= MODE_RAMP;
            inc_a   <= INC_RST;
            level_a <= MID;
        end else if (commit) begin
            mode_a  <= mode_s;
            inc_a   <= inc_s;
            level_a <= level_s;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (advance)
            acc <= acc + inc_a;
    end

    always_comb begin
        p    = acc[ACC_W-2 -: DATA_W];
        wave = mode_a == MODE_RAMP     ? acc[ACC_W-1 -: DATA_W] :
               mode_a == MODE_TRIANGLE ? (acc[ACC_W-1] ? ~p : p) :
               mode_a == MODE_SQUARE   ? {DATA_W{acc[ACC_W-1]}} :
                                         level_a;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            dout <= MID ^ OUT_XOR;
        else
            dout <= (stop ? MID : wave) ^ OUT_XOR;
    end
endmodule

// File: rtl/dac_wavegen.sv
// dac_wavegen: multi-channel DAC waveform generator - controller FSM, channel write decode, DAC clock forwarding.
// Build option DAC_WAVEGEN_INVERT_EN selects inverted DAC data in every channel.
module dac_wavegen
    import dac_wavegen_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 16
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic                       run,
    input  logic                       cfg_we,
    input  logic [2:0]                 cfg_ch,
    input  logic [1:0]                 cfg_addr,
    input  logic [ACC_W-1:0]           cfg_data,
    input  logic                       cfg_commit,
    output logic                       running,
    output logic [CHANNELS*DATA_W-1:0] dac_d,
    output logic [CHANNELS-1:0]        dac_c
);
    state_t state, state_n;
    logic   clear, advance, stop;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            state <= ST_STOP;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = !run ? ST_STOP : (state == ST_STOP ? ST_ARM : ST_RUN);
        clear   = state == ST_ARM;
        advance = state == ST_RUN;
        stop    = state != ST_RUN;
        running = state != ST_STOP;
    end

    // The DACs latch half a cycle after dac_d changes.
    assign dac_c = {CHANNELS{~clk}};

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        dac_wavegen_ch #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_ch (
            .clk    (clk),
            .nReset (nReset),
            .we     (cfg_we && cfg_ch == 3'(k)),
            .addr   (cfg_addr),
            .data   (cfg_data),
            .clear  (clear),
            .advance(advance),
            .commit (cfg_commit),
            .stop   (stop),
            .dout   (dac_d[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_dac_wavegen.sv
// tb_dac_wavegen: scoreboard bench for dac_wavegen with default parameters (2 channels, 8-bit data, 16-bit accumulator).
module tb_dac_wavegen;
    import dac_wavegen_pkg::*;

    localparam logic [7:0] MID = 8'h80;
`ifdef DAC_WAVEGEN_INVERT_EN
    localparam logic [15:0] INV = 16'hFFFF;
`else
    localparam logic [15:0] INV = 16'h0000;
`endif

    logic        clk = 0, nReset = 0, run = 0, cfg_we = 0, cfg_commit = 0;
    logic [2:0]  cfg_ch = 0;
    logic [1:0]  cfg_addr = 0;
    logic [15:0] cfg_data = 0;
    logic        running;
    logic [15:0] dac_d;
    logic [1:0]  dac_c;
    logic [15:0] sb[$];
    int          tests = 0, failed = 0;

    dac_wavegen dut (
        .clk       (clk),
        .nReset    (nReset),
        .run       (run),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_commit(cfg_commit),
        .running   (running),
        .dac_d     (dac_d),
        .dac_c     (dac_c)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tri_v(input int i);
        int m = i % 128;
        return m < 64 ? 8'(4 * m) : 8'(255 - 4 * (m - 64));
    endfunction

    function automatic logic [7:0] sq_v(input int i);
        return (i % 2) == 1 ? 8'hFF : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c1, input logic [7:0] c0);
        sb.push_back({c1, c0});
    endtask

    task automatic step(input string tag);
        logic [15:0] e;
        tick();
        if (sb.size() == 0)
            check({tag, "_sb_empty"}, 32'(sb.size()), 1);
        else begin
            e = sb.pop_front();
            check(tag, {16'd0, dac_d ^ INV}, {16'd0, e});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push(MID, MID);
            step("idle_mid");
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_ch = ch; cfg_addr = a; cfg_data = d;
        push(MID, MID);
        step("cfg_mid");
        cfg_we = 0;
    endtask

    task automatic commit_stopped();
        cfg_commit = 1;
        push(MID, MID);
        step("commit_mid");
        cfg_commit = 0;
    endtask

    task automatic run_start();
        run = 1;
        push(MID, MID);
        step("arm_mid");
        check("running_arm", running, 1);
        push(MID, MID);
        step("arm_mid2");
    endtask

    initial begin
        int j;
        // reset state and DAC clock forwarding
        repeat (3) tick();
        check("rst_dac", dac_d ^ INV, {MID, MID});
        check("rst_running", running, 0);
        check("dac_c_high_clk", dac_c, 2'b00);
        @(negedge clk); #1;
        check("dac_c_low_clk", dac_c, 2'b11);
        tick();
        nReset = 1;
        idle(2);

        // default ramp on both channels, wrap, then stop
        run_start();
        for (int i = 0; i <= 256; i++) push(8'(i), 8'(i));
        for (int i = 0; i <= 256; i++) step("ramp");
        run = 0;
        push(8'd1, 8'd1);
        step("ramp_last");
        check("running_stop", running, 0);
        push(MID, MID);
        step("stop_mid");

        // ch1 triangle; writes to ch5/ch7 and reserved address must change nothing
        wr(3'd1, CFG_MODE, 16'd1);
        wr(3'd1, CFG_INC, 16'h0200);
        wr(3'd5, CFG_INC, 16'h0000);
        wr(3'd7, CFG_MODE, 16'h0003);
        wr(3'd0, CFG_RSVD, 16'h0000);
        commit_stopped();
        idle(1);
        run_start();
        for (int i = 0; i < 130; i++) begin
            push(tri_v(i), 8'(i));
            step("tri");
        end
        run = 0;
        push(tri_v(130), 8'd130);
        step("tri_last");
        push(MID, MID);
        step("tri_stop_mid");

        // ch0 square at half-rate
        wr(3'd0, CFG_MODE, 16'd2);
        wr(3'd0, CFG_INC, 16'h8000);
        commit_stopped();
        run_start();
        for (j = 0; j < 8; j++) begin
            push(tri_v(j), sq_v(j));
            step("square");
        end

        // level write, then mode write coinciding with commit: old mode must persist
        cfg_we = 1; cfg_ch = 0; cfg_addr = CFG_LEVEL; cfg_data = 16'h005A;
        push(tri_v(j), sq_v(j)); step("lvl_wr"); j++;
        cfg_addr = CFG_MODE; cfg_data = 16'h0003; cfg_commit = 1;
        push(tri_v(j), sq_v(j)); step("mode_wr_commit"); j++;
        cfg_we = 0; cfg_commit = 0;
        repeat (3) begin
            push(tri_v(j), sq_v(j)); step("old_mode"); j++;
        end
        cfg_commit = 1;
        push(tri_v(j), sq_v(j)); step("commit2_edge"); j++;
        cfg_commit = 0;
        repeat (3) begin
            push(tri_v(j), 8'h5A); step("const_lvl"); j++;
        end

        // asynchronous reset during RUN
        @(posedge clk); #2;
        nReset = 0;
        #1;
        check("async_rst_dac", dac_d ^ INV, {MID, MID});
        check("async_rst_running", running, 0);
        run = 0;
        tick();
        nReset = 1;
        idle(1);
        run_start();
        for (int i = 0; i < 4; i++) begin
            push(8'(i), 8'(i));
            step("post_rst_ramp");
        end
        check("sb_drain", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
